operand_queue: RTL

OPERAND_QUEUE -- requirements
Module: operand_queue

---
 rtl/queue_cal_pkg.sv | 13 +
 rtl/queue_mem.sv | 28 ++
 rtl/operand_queue.sv | 118 +++++++++++
 3 files changed

// File: rtl/queue_cal_pkg.sv
// Shared definitions for the queue-based calculator: queue op codes and datapath width.
package queue_cal_pkg;

    localparam int QUEUE_DATA_W = 8;

    typedef enum logic [1:0] {
        Q_PUSH         = 2'd0,
        Q_SLEEP        = 2'd1,
        Q_GET_AND_PUSH = 2'd2,
        Q_POP          = 2'd3
    } queue_op_e;

endpackage

// File: rtl/queue_mem.sv
// Operand storage: one synchronous write port, two asynchronous read ports, no reset.
module queue_mem #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr0,
    input  logic [AW-1:0]     raddr1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/operand_queue.sv
// Circular operand queue feeding the ALU with its two oldest entries; the ALU result is pushed back.
module operand_queue
    import queue_cal_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = QUEUE_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  op_valid,
    input  logic [1:0]            queue_op,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  err_clr,
    output logic [2*DATA_W-1:0]   operands,
    output logic [$clog2(DEPTH):0] count,
    output logic                  empty,
    output logic                  full,
    output logic                  has_two,
    output logic                  op_done,
    output logic                  ovf_err,
    output logic                  unf_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    queue_op_e         op;
    logic [AW-1:0]     head;
    logic [AW-1:0]     tail;
    logic [CW-1:0]     count_q;
    logic [DATA_W-1:0] rd_head;
    logic [DATA_W-1:0] rd_next;
    logic              do_push;
    logic              do_pop;
    logic              do_gap;
    logic              set_ovf;
    logic              set_unf;

    assign op      = queue_op_e'(queue_op);
    assign count   = count_q;
    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign has_two = (count_q >= CW'(2));

    always_comb begin
        do_push = 1'b0;
        do_pop  = 1'b0;
        do_gap  = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        if (op_valid) begin
            case (op)
                Q_PUSH: begin
                    if (full) set_ovf = 1'b1;
                    else      do_push = 1'b1;
                end
                Q_POP: begin
                    if (empty) set_unf = 1'b1;
                    else       do_pop  = 1'b1;
                end
                Q_GET_AND_PUSH: begin
                    if (has_two) do_gap  = 1'b1;
                    else         set_unf = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // When full, tail==head: GET_AND_PUSH overwrites the slot it consumes in the same cycle.
    queue_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_mem (
        .clk    (clk),
        .we     (do_push | do_gap),
        .waddr  (tail),
        .wdata  (wdata),
        .raddr0 (head),
        .raddr1 (head + AW'(1)),
        .rdata0 (rd_head),
        .rdata1 (rd_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            op_done <= 1'b0;
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            op_done <= op_valid;
            if (do_push) begin
                tail    <= tail + AW'(1);
                count_q <= count_q + CW'(1);
            end
            if (do_pop) begin
                head    <= head + AW'(1);
                count_q <= count_q - CW'(1);
            end
            if (do_gap) begin
                head    <= head + AW'(2);
                tail    <= tail + AW'(1);
                count_q <= count_q - CW'(1);
            end
            ovf_err <= set_ovf | (ovf_err & ~err_clr);
            unf_err <= set_unf | (unf_err & ~err_clr);
        end
    end

    // Stale memory is masked so invalid slots never reach the ALU.
    assign operands[2*DATA_W-1:DATA_W] = empty   ? '0 : rd_head;
    assign operands[DATA_W-1:0]        = has_two ? rd_next : '0;

endmodule
